// File: rtl/tree_find_sequencer.sv
// Walks a search key down the Index block tree, one level per clock, and returns
// a registered found/not-found/error result over a valid/ready handshake.
module tree_find_sequencer #(
  parameter int pRootAddress = 1,
  parameter int pMaxDepth    = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_found,
  output logic [7:0] out_data,
  output logic [3:0] out_depth,
  output logic       out_error,
  output logic [7:0] node_key,
  output logic [7:0] node_address,
  input  logic       node_found,
  input  logic [7:0] node_data,
  input  logic [7:0] node_next,
  output logic [1:0] state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds valid and payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ROOT_ADDR = 8'(pRootAddress);
  localparam logic [3:0] MAX_DEPTH = 4'(pMaxDepth);

  state_t     state;
  logic [3:0] depth;

  assign state_dbg = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      depth        <= 4'd0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_found    <= 1'b0;
      out_error    <= 1'b0;
      out_data     <= 8'd0;
      out_depth    <= 4'd0;
      node_key     <= 8'd0;
      node_address <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          in_ready     <= 1'b1;
          node_address <= 8'd0;
          if (in_valid && in_ready) begin
            node_key     <= in_key;
            node_address <= ROOT_ADDR;
            depth        <= 4'd1;
            in_ready     <= 1'b0;
            state        <= WALK;
          end
        end

        WALK: begin
          // Any resolution lands in DONE with the probed depth and a parked address.
          if (node_found || node_next == 8'd0 || depth == MAX_DEPTH) begin
            out_depth    <= depth;
            node_address <= 8'd0;
            out_valid    <= 1'b1;
            state        <= DONE;
            if (node_found) begin
              out_found <= 1'b1;
              out_data  <= node_data;
              out_error <= 1'b0;
            end else begin
              out_found <= 1'b0;
              out_data  <= 8'd0;
              out_error <= (node_next != 8'd0);
            end
          end else begin
            node_address <= node_next;
            depth        <= depth + 4'd1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_found <= 1'b0;
            out_error <= 1'b0;
            out_data  <= 8'd0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_find_sequencer.sv
// Directed bench for tree_find_sequencer: a behavioural node array, a vector
// table of searches, and hand-written backpressure and mid-walk reset sequences.
module tb_tree_find_sequencer;

  localparam int MAX_DEPTH = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_key = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_found;
  logic [7:0] out_data;
  logic [3:0] out_depth;
  logic       out_error;
  logic [7:0] node_key;
  logic [7:0] node_address;
  logic       node_found;
  logic [7:0] node_data;
  logic [7:0] node_next;
  logic [1:0] state_dbg;

  bit cyclic = 1'b0;
  int errors = 0;
  int checks = 0;

  tree_find_sequencer #(.pRootAddress(1), .pMaxDepth(MAX_DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_found(out_found),
    .out_data(out_data), .out_depth(out_depth), .out_error(out_error),
    .node_key(node_key), .node_address(node_address),
    .node_found(node_found), .node_data(node_data), .node_next(node_next),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Node array: tree (block 1 root, block 3 leaf) or a 1 <-> 2 cycle with no keys.
  always_comb begin
    node_found = 1'b0;
    node_data  = 8'd0;
    node_next  = 8'd0;
    if (cyclic) begin
      if (node_address == 8'd1)      node_next = 8'd2;
      else if (node_address == 8'd2) node_next = 8'd1;
    end else if (node_address == 8'd1) begin
      case (node_key)
        8'd10: begin node_found = 1'b1; node_data = 8'hA1; end
        8'd20: begin node_found = 1'b1; node_data = 8'hA2; end
        8'd30: begin node_found = 1'b1; node_data = 8'hA3; end
        default: begin
          if (node_key < 8'd10)      node_next = 8'd2;
          else if (node_key < 8'd20) node_next = 8'd3;
          else if (node_key < 8'd30) node_next = 8'd4;
          else                       node_next = 8'd5;
        end
      endcase
    end else if (node_address == 8'd3) begin
      case (node_key)
        8'd12: begin node_found = 1'b1; node_data = 8'hB1; end
        8'd14: begin node_found = 1'b1; node_data = 8'hB2; end
        8'd16: begin node_found = 1'b1; node_data = 8'hB3; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents a request and returns 1 ns after the accept edge.
  task automatic launch(input logic [7:0] key);
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_key   = key;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_key   = 8'($urandom_range(0, 255));
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
    check("root_address", {24'd0, node_address}, 32'd1);
    check("node_key_held", {24'd0, node_key}, {24'd0, key});
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("result_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic take;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("take_valid_low", {31'd0, out_valid}, 32'd0);
    check("take_found_low", {31'd0, out_found}, 32'd0);
    check("take_error_low", {31'd0, out_error}, 32'd0);
    check("take_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] key;
    bit         cyc;
    logic       found;
    logic [7:0] data;
    logic [3:0] depth;
    logic       error;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;

    vecs[0]  = '{8'd10, 1'b0, 1'b1, 8'hA1, 4'd1, 1'b0};
    vecs[1]  = '{8'd20, 1'b0, 1'b1, 8'hA2, 4'd1, 1'b0};
    vecs[2]  = '{8'd30, 1'b0, 1'b1, 8'hA3, 4'd1, 1'b0};
    vecs[3]  = '{8'd14, 1'b0, 1'b1, 8'hB2, 4'd2, 1'b0};
    vecs[4]  = '{8'd12, 1'b0, 1'b1, 8'hB1, 4'd2, 1'b0};
    vecs[5]  = '{8'd16, 1'b0, 1'b1, 8'hB3, 4'd2, 1'b0};
    vecs[6]  = '{8'd13, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0};
    vecs[7]  = '{8'd5,  1'b0, 1'b0, 8'h00, 4'd2, 1'b0};
    vecs[8]  = '{8'd25, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0};
    vecs[9]  = '{8'd99, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0};
    vecs[10] = '{8'd99, 1'b1, 1'b0, 8'h00, 4'd4, 1'b1};
    vecs[11] = '{8'd0,  1'b1, 1'b0, 8'h00, 4'd4, 1'b1};

    // Reset values, then in_ready on the first edge after release.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {out_found, out_error, out_data, out_depth, node_key, node_address},
          32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    check("pre_edge_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    check("first_edge_in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      cyclic = vecs[i].cyc;
      launch(vecs[i].key);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), lat, {28'd0, vecs[i].depth});
      check($sformatf("v%0d_found", i), {31'd0, out_found}, {31'd0, vecs[i].found});
      check($sformatf("v%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].data});
      check($sformatf("v%0d_depth", i), {28'd0, out_depth}, {28'd0, vecs[i].depth});
      check($sformatf("v%0d_error", i), {31'd0, out_error}, {31'd0, vecs[i].error});
      check($sformatf("v%0d_addr_parked", i), {24'd0, node_address}, 32'd0);
      take();
    end
    cyclic = 1'b0;

    // Backpressure: result held for 5 cycles while in_valid pulses.
    launch(8'd20);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      in_valid = c[0];
      in_key   = 8'd14;
      @(posedge clock);
      #1;
      check($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d_data", c), {24'd0, out_data}, 32'hA2);
      check($sformatf("bp%0d_found", c), {31'd0, out_found}, 32'd1);
      check($sformatf("bp%0d_depth", c), {28'd0, out_depth}, 32'd1);
      check($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    take();
    @(posedge clock);
    #1;
    check("bp_no_stray_walk", {30'd0, state_dbg}, 32'd0);
    check("bp_idle_addr", {24'd0, node_address}, 32'd0);

    // Reset asserted while probing level 2 of key 14.
    launch(8'd14);
    @(posedge clock);
    #1;
    check("mid_walk_addr", {24'd0, node_address}, 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_outputs", {out_valid, out_found, out_error, in_ready, out_data, out_depth,
                                node_key, node_address}, 32'd0);
    check("async_rst_state", {30'd0, state_dbg}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("rst_hold%0d_valid", c), {31'd0, out_valid}, 32'd0);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    launch(8'd30);
    wait_result(lat);
    check("post_rst_latency", lat, 32'd1);
    check("post_rst_found", {31'd0, out_found}, 32'd1);
    check("post_rst_data", {24'd0, out_data}, 32'hA3);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
